// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum magnitude ping-pong store.
package spectrum_pkg;

   localparam int NUM_BINS   = 512;
   localparam int BIN_W      = 9;
   localparam int MAG_W_DFLT = 16;
   localparam int CNT_W_DFLT = 16;

   typedef logic [BIN_W-1:0]      bin_idx_t;
   typedef logic [MAG_W_DFLT-1:0] mag_t;

   typedef enum logic {
      FILL    = 1'b0,
      PENDING = 1'b1
   } wr_state_t;

   // Flat RAM address: bank select sits above the bin index.
   function automatic logic [BIN_W:0] bank_addr(input logic bank, input bin_idx_t bin);
      return {bank, bin};
   endfunction

endpackage

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port RAM holding both spectrum banks in one array so that a
// single block RAM is inferred. One write port, one registered read port.
module spectrum_bank_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port; contents are intentionally never cleared.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read; output holds its value while no read is requested.
   always_ff @(posedge clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/spectrum_bank_ctrl.sv
// Ping-pong controller between the FFT magnitude writer and the display
// reader. Banks swap only on a frame_start while a complete frame is pending,
// so the displayed frame never tears.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FILL    | accepting FFT beats into the write bank (~disp_bank)
//   PENDING | full frame written, waiting for frame_start to swap banks;
//           | incoming beats are dropped and counted
module spectrum_bank_ctrl
   import spectrum_pkg::*;
#(
   parameter int MAG_W = MAG_W_DFLT,
   parameter int CNT_W = CNT_W_DFLT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   input  logic [BIN_W-1:0] i_wr_bin,
   input  logic [MAG_W-1:0] i_wr_mag,
   input  logic             i_wr_last,
   input  logic             i_frame_start,
   input  logic             i_rd_valid,
   input  logic [BIN_W-1:0] i_rd_bin,
   output logic [MAG_W-1:0] o_rd_mag,
   output logic             o_rd_mag_valid,
   output logic             o_swap_pulse,
   output logic             o_disp_bank,
   output logic [CNT_W-1:0] o_frames_shown,
   output logic [CNT_W-1:0] o_drop_cnt
);

   wr_state_t        r_state;
   wr_state_t        w_state_nxt;

   logic             r_disp_bank;
   logic             r_have_frame;
   logic             r_swap_pulse;
   logic             r_rd_mag_valid;
   logic             r_rd_open;
   logic [CNT_W-1:0] r_frames_shown;
   logic [CNT_W-1:0] r_drop_cnt;

   logic             w_wr_ready;
   logic             w_wr_en;
   logic             w_swap;
   logic             w_drop;
   logic [BIN_W:0]   w_waddr;
   logic [BIN_W:0]   w_raddr;
   logic [MAG_W-1:0] w_ram_rdata;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state. A frame_start that coincides with the last beat does not
   // swap; the pending frame waits for the following frame_start.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL: begin
            if (i_wr_valid && i_wr_last) begin
               w_state_nxt = PENDING;
            end
         end
         PENDING: begin
            if (i_frame_start) begin
               w_state_nxt = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   // FSM outputs, decoded from state; ready never depends on wr_valid.
   always_comb begin
      w_wr_ready = 1'b0;
      w_wr_en    = 1'b0;
      w_swap     = 1'b0;
      w_drop     = 1'b0;
      case (r_state)
         FILL: begin
            w_wr_ready = 1'b1;
            w_wr_en    = i_wr_valid;
         end
         PENDING: begin
            w_drop = i_wr_valid;
            w_swap = i_frame_start;
         end
         default: begin
            w_wr_ready = 1'b0;
         end
      endcase
   end

   // Bank selection, frame flag and swap strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp_bank  <= 1'b0;
         r_have_frame <= 1'b0;
         r_swap_pulse <= 1'b0;
      end else begin
         r_swap_pulse <= w_swap;
         if (w_swap) begin
            r_disp_bank  <= ~r_disp_bank;
            r_have_frame <= 1'b1;
         end
      end
   end

   // Saturating frame and drop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frames_shown <= '0;
         r_drop_cnt     <= '0;
      end else begin
         if (w_swap && !(&r_frames_shown)) begin
            r_frames_shown <= r_frames_shown + 1'b1;
         end
         if (w_drop && !(&r_drop_cnt)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   // Read qualifier and the have_frame gate, both captured in the request
   // cycle so they line up with the RAM's registered data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_mag_valid <= 1'b0;
         r_rd_open      <= 1'b0;
      end else begin
         r_rd_mag_valid <= i_rd_valid;
         if (i_rd_valid) begin
            r_rd_open <= r_have_frame;
         end
      end
   end

   // Writer always targets the bank not being displayed, so the two ports
   // never touch the same bank.
   assign w_waddr = bank_addr(~r_disp_bank, i_wr_bin);
   assign w_raddr = bank_addr(r_disp_bank, i_rd_bin);

   spectrum_bank_ram #(
      .ADDR_W (BIN_W + 1),
      .DATA_W (MAG_W)
   ) u_bank_ram (
      .clk     (clk),
      .i_we    (w_wr_en),
      .i_waddr (w_waddr),
      .i_wdata (i_wr_mag),
      .i_re    (i_rd_valid),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_rdata)
   );

   assign o_wr_ready     = w_wr_ready;
   assign o_rd_mag       = r_rd_open ? w_ram_rdata : '0;
   assign o_rd_mag_valid = r_rd_mag_valid;
   assign o_swap_pulse   = r_swap_pulse;
   assign o_disp_bank    = r_disp_bank;
   assign o_frames_shown = r_frames_shown;
   assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: doc/spectrum_bank_ctrl.md
Name: spectrum_bank_ctrl

Overview:
Ping-pong controller for the spectrum magnitude store between the FFT magnitude stream (writer) and the log-frequency display path (reader).
- The writer fills one 512-bin bank while the display reads the other bank.
- Banks swap only on a display frame boundary, so a displayed frame never tears.
- It sits after the FFT magnitude stage. Its read side is addressed by the registered bin_index/bin_valid from the log x-mapping stage.

Parameters:
MAG_W, 16, magnitude width per bin
NUM_BINS, 512, bins per bank (power of two; address width BIN_W = log2(NUM_BINS) = 9)
CNT_W, 16, width of frame and drop counters (saturating)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_valid  in  1  FFT beat valid
wr_ready  out  1  controller accepts beat
wr_bin  in  BIN_W  bin address of beat
wr_mag  in  MAG_W  magnitude of beat
wr_last  in  1  final beat of FFT frame
frame_start  in  1  one-cycle pulse at start of vertical blanking
rd_valid  in  1  display read request (bin_valid)
rd_bin  in  BIN_W  display read address (bin_index)
rd_mag  out  MAG_W  magnitude read from display bank
rd_mag_valid  out  1  rd_mag qualifier
swap_pulse  out  1  one-cycle pulse when banks swap
disp_bank  out  1  bank currently displayed
frames_shown  out  CNT_W  count of swaps
drop_cnt  out  CNT_W  count of beats offered while wr_ready=0

Behaviour:
- Write FSM has two states: FILL and PENDING. Write bank is always ~disp_bank.
- Reset values:
  - state=FILL, disp_bank=0, have_frame=0.
  - rd_mag=0, rd_mag_valid=0, swap_pulse=0, frames_shown=0, drop_cnt=0.
  - RAM contents are not reset.
- wr_ready = (state==FILL). It is decoded from state only, with no dependency on wr_valid.
- FILL:
  - A beat is accepted when wr_valid&&wr_ready; it writes wr_mag to the write bank at wr_bin on that edge.
  - An accepted beat with wr_last moves the FSM to PENDING.
  - Bins not written in a frame keep their stale values. No completeness check.
- PENDING:
  - wr_valid beats are discarded, and drop_cnt increments once per such cycle (saturates at all-ones).
  - On frame_start: disp_bank toggles, have_frame<=1, frames_shown++ (saturating), swap_pulse=1 for exactly one cycle, state goes to FILL.
- frame_start while in FILL causes no swap and no other effect.
- frame_start in the same cycle as an accepted wr_last: the last beat is written and the FSM enters PENDING. The swap waits for the next frame_start; there is no same-cycle swap.
- Read latency is 1 cycle:
  - rd_mag_valid(t+1) = rd_valid(t).
  - rd_mag(t+1) = bank[disp_bank(t)][rd_bin(t)].
  - The bank is sampled in the request cycle, so a read issued in the cycle before a swap returns old-bank data.
- While have_frame=0, rd_mag is forced to 0 (rd_mag_valid still follows rd_valid).
- When rd_valid=0, rd_mag holds its previous value.
- Reader and writer never access the same bank, so no read/write collision is possible.
- Reset mid-frame: the FSM returns to FILL and bank 0 is displayed. The partially written bank is reused, and writes restart at whatever wr_bin arrives next.

Decomposition:
- spectrum_pkg holds:
  - NUM_BINS=512, BIN_W=9, MAG_W default 16.
  - typedef bin_idx_t, typedef mag_t.
  - enum wr_state_t {FILL, PENDING}.
- One sub-module: spectrum_bank_ram, a simple dual-port RAM (1 write, 1 registered read) of 2*NUM_BINS x MAG_W, addressed {bank,bin}.
  - Bank RAM is instantiated once as a single 1024-deep memory so it infers one BRAM.
- The controller holds the FSM, counters, output muxing and the have_frame gate.

Test Plan:
- After reset, issue rd_valid with rd_bin=5 -> rd_mag_valid=1 next cycle, rd_mag=0, disp_bank=0, wr_ready=1.
- Write bins 0..511 with mag=bin*3, wr_last on 511, then pulse frame_start -> swap_pulse=1 for one cycle, disp_bank=1, frames_shown=1; read rd_bin=100 -> rd_mag=300 one cycle later.
- While PENDING, drive wr_valid for 7 cycles -> wr_ready=0 throughout, drop_cnt=7, bank contents unchanged; then frame_start -> state FILL, wr_ready=1.
- Assert frame_start in the same cycle as accepted wr_last -> no swap_pulse that cycle, PENDING entered; next frame_start -> swap, frames_shown increments by 1.
- Issue rd_valid rd_bin=10 in the cycle before swap, with old bank=111 and new bank=222 -> rd_mag=111; the read after the swap returns 222.
- Assert rst during a partial fill (bins 0..199 written) -> all outputs return to reset values, rd_mag=0 until the next completed frame and swap.
